// File: rtl/bp_serial_collector.sv
// ---------------------------------------------------------------------------
// bp_serial_collector
//
// Collects full-width words from the butterfly processor serial port into a
// small FIFO and presents them, head first, to a bank of AXI write masters.
// A transfer is started with a one-cycle start pulse that carries the beat
// count. Every accepted word is tagged as "last" when it is the final beat
// of the transfer. Once the last word has been accepted, the block stops
// accepting input and drains. When the last-tagged word has been popped it
// returns to idle and pulses done.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle pulse that begins a transfer (ignored while busy)
//   length[15:0] : beats in the transfer, sampled with an accepted start
//   in_vld       : per-channel valid from the serial port (OUTPUT_AXI_CHNL)
//   in_dat       : serial data word (DATA_WIDTH_AXI*OUTPUT_AXI_CHNL)
//   in_rdy       : collector can accept a word this cycle
//   out_vld      : per-channel valid toward the AXI write masters
//   out_dat      : head word of the buffer (zero while empty)
//   out_last     : head word is the final beat of the transfer
//   out_rdy      : downstream accepts the head word
//   busy         : a transfer is in progress (not idle)
//   done         : one-cycle pulse at transfer completion
//   err_partial  : sticky flag, some but not all channels valid during run
// ---------------------------------------------------------------------------
module bp_serial_collector #(
  parameter int DATA_WIDTH_AXI  = 256,
  parameter int OUTPUT_AXI_CHNL = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [15:0]                               length,
  input  logic [OUTPUT_AXI_CHNL-1:0]                in_vld,
  input  logic [DATA_WIDTH_AXI*OUTPUT_AXI_CHNL-1:0] in_dat,
  output logic                                      in_rdy,
  output logic [OUTPUT_AXI_CHNL-1:0]                out_vld,
  output logic [DATA_WIDTH_AXI*OUTPUT_AXI_CHNL-1:0] out_dat,
  output logic                                      out_last,
  input  logic                                      out_rdy,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_partial
);

  localparam int DW = DATA_WIDTH_AXI * OUTPUT_AXI_CHNL;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_DEPTH-1:0] last_tag_q, last_tag_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Data storage. Not reset: contents are only visible through the head
  // when the FIFO is non-empty, and out_dat is forced to zero when empty.
  logic [DW-1:0] dat_mem [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic vld_all;
  logic vld_none;
  logic push;
  logic pop;
  logic push_is_last;
  logic head_last;

  // -------------------------------------------------------------------------
  // Handshake decode. in_rdy depends only on registered state and occupancy,
  // so a full FIFO refuses input even if the head is popped in the same
  // cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == DEPTH_C);
    vld_all      = &in_vld;
    vld_none     = ~|in_vld;
    in_rdy       = (state_q == RUN) && !fifo_full;
    push         = in_rdy && vld_all;
    pop          = !fifo_empty && out_rdy;
    push_is_last = (acc_cnt_q == (len_q - 16'd1));
    head_last    = last_tag_q[rd_ptr_q];
  end

  // -------------------------------------------------------------------------
  // Next-state logic: transfer control and FIFO bookkeeping.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_cnt_d  = acc_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_tag_d = last_tag_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (length == 16'd0) begin
            // Empty transfer: nothing to move, just acknowledge it.
            done_d = 1'b1;
          end else begin
            len_d     = length;
            acc_cnt_d = 16'd0;
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        // A word with only some channels valid is dropped and flagged.
        if (!vld_all && !vld_none) begin
          err_d = 1'b1;
        end
        if (push) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (push_is_last) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The last-tagged entry can only reach the head after the push
        // that moved us here, so completion is only detected in DRAIN.
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d             = wr_ptr_q + PW'(1);
      last_tag_d[wr_ptr_q] = push_is_last;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers with asynchronous reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      acc_cnt_q  <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_tag_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_tag_q <= last_tag_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_mem[wr_ptr_q] <= in_dat;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The head is read straight from storage so a word pushed into
  // an empty FIFO is visible the following cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    out_vld     = {OUTPUT_AXI_CHNL{!fifo_empty}};
    out_dat     = fifo_empty ? '0 : dat_mem[rd_ptr_q];
    out_last    = !fifo_empty && head_last;
    busy        = (state_q != IDLE);
    done        = done_q;
    err_partial = err_q;
  end

endmodule

// File: doc/bp_serial_collector.md
BP_SERIAL_COLLECTOR -- requirements
Module: bp_serial_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH_AXI, default 256: bits per output AXI channel beat.
REQ-002 SHALL have parameter OUTPUT_AXI_CHNL, default 8: number of output AXI channels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of full-width words buffered (power of two, ≥2).
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a transfer.
REQ-007 SHALL have port length, input, 16: beats in the transfer, sampled on accepted start.
REQ-008 SHALL have port in_vld, input, OUTPUT_AXI_CHNL: per-channel valid from the butterfly processor serial port.
REQ-009 SHALL have port in_dat, input, DATA_WIDTH_AXI*OUTPUT_AXI_CHNL: serial output data word.
REQ-010 SHALL have port in_rdy, output, 1: collector can accept a word.
REQ-011 SHALL have port out_vld, output, OUTPUT_AXI_CHNL: per-channel valid toward AXI write masters.
REQ-012 SHALL have port out_dat, output, DATA_WIDTH_AXI*OUTPUT_AXI_CHNL: head word of buffer.
REQ-013 SHALL have port out_last, output, 1: head word is final beat of transfer.
REQ-014 SHALL have port out_rdy, input, 1: downstream accepts head word.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at transfer completion.
REQ-017 SHALL have port err_partial, output, 1: sticky partial-valid error flag.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 IDLE, start=1, length≠0: SHALL latch length, clear accept/pop counters and err_partial, go to RUN next cycle.
REQ-020 IDLE, start=1, length=0: SHALL stay IDLE, clear err_partial, pulse done the next cycle.
REQ-021 start while busy=1 SHALL be ignored; latched length unchanged.
REQ-022 in_rdy SHALL be 1 only in RUN with FIFO occupancy < FIFO_DEPTH, combinational from registered state/occupancy only.
REQ-023 A word SHALL be pushed iff in_rdy=1 and in_vld all ones; no push at occupancy FIFO_DEPTH, even with simultaneous pop.
REQ-024 In RUN, in_vld neither all-zero nor all-ones SHALL set err_partial (held until next accepted start); that word is not pushed.
REQ-025 Each pushed entry SHALL carry a last tag = (accept count == length−1); accept counter is 16-bit.
REQ-026 On push of the tagged-last word SHALL go to DRAIN next cycle (in_rdy=0 from then).
REQ-027 out_vld SHALL equal {OUTPUT_AXI_CHNL{FIFO non-empty}}; out_dat/out_last from head entry registers.
REQ-028 Pop SHALL occur iff out_vld[0]=1 and out_rdy=1; out_dat/out_last held stable while out_vld=1 and out_rdy=0.
REQ-029 Latency: word pushed in cycle N SHALL appear on out_dat no earlier than N+1 (N+1 when FIFO was empty); no combinational in→out path.
REQ-030 Simultaneous push and pop below full SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 Pop of the last-tagged entry in DRAIN SHALL return to IDLE next cycle and pulse done for exactly one cycle.
REQ-032 in_dat/in_vld SHALL be ignored in IDLE and DRAIN.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, FIFO empty, counters 0, in_rdy=0, out_vld=0, out_last=0, busy=0, done=0, err_partial=0; out_dat 0.
REQ-034 Reset mid-transfer SHALL discard buffered words; next start begins fresh.

Verification
REQ-035 start, length=3, in_vld=8'hFF words A,B,C back-to-back, out_rdy=1 -> out A,B,C on consecutive cycles, out_last only with C, done 1 cycle after C pops.
REQ-036 length=6, out_rdy=0 -> in_rdy drops after 4 accepts; out_rdy=1 -> remaining 2 accepted, 6 pops in order, out_last on 6th.
REQ-037 RUN, in_vld=8'h0F -> err_partial=1, word not pushed, accept count unchanged; next start clears it.
REQ-038 start with length=0 -> busy stays 0, done pulses next cycle, no out_vld.
REQ-039 start during RUN with length=9 (orig 2) -> ignored; transfer ends after 2 beats.
REQ-040 rst_n low with 3 words buffered -> out_vld=0 immediately; after release, start length=1 -> single beat with out_last=1.
